// File: rtl/instr_fetch_unit_pkg.sv
// ============================================================================
// instr_fetch_unit_pkg : shared encodings, state type and default addresses
// Rev 1.0
// ============================================================================
`default_nettype none

package instr_fetch_unit_pkg;

  localparam logic [1:0] PCSRC_SEQ = 2'd0;
  localparam logic [1:0] PCSRC_BR  = 2'd1;
  localparam logic [1:0] PCSRC_J   = 2'd2;
  localparam logic [1:0] PCSRC_JR  = 2'd3;

  localparam logic [31:0] DEFAULT_RESET_PC   = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_EXC_VECTOR = 32'h8000_0180;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } fetch_state_e;

endpackage

`default_nettype wire

// File: rtl/instr_fetch_unit_pc_next_mux.sv
// ============================================================================
// pc_next_mux : selects the PC update target from pc_src
// Rev 1.0
// ============================================================================
`default_nettype none

module pc_next_mux
  import instr_fetch_unit_pkg::*;
(
  input  logic [1:0]  pc_src_i,
  input  logic [31:0] pc_i,
  input  logic [25:0] jidx_i,
  input  logic [31:0] branch_target_i,
  input  logic [31:0] jr_target_i,
  output logic [31:0] target_o
);

  always_comb begin
    target_o = pc_i;
    unique case (pc_src_i)
      PCSRC_SEQ: target_o = pc_i;
      PCSRC_BR:  target_o = branch_target_i;
      PCSRC_J:   target_o = {pc_i[31:28], jidx_i, 2'b00};
      PCSRC_JR:  target_o = jr_target_i;
      default:   target_o = pc_i;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/instr_fetch_unit.sv
// ============================================================================
// instr_fetch_unit : fetch FSM, PC/IR registers and field decode
// Optional macro FETCH_EXC_VECTOR_EN enables exception vectoring and epc.
// Rev 1.0
// ============================================================================
`default_nettype none

module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter logic [31:0] EXC_VECTOR = DEFAULT_EXC_VECTOR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ir_write,
  input  logic        pc_write,
  input  logic [1:0]  pc_src,
  input  logic [31:0] branch_target,
  input  logic [31:0] jr_target,
  input  logic        exc_req,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [5:0]  opcode,
  output logic [5:0]  funct,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [15:0] imm,
  output logic [31:0] pc,
  output logic [31:0] epc,
  output logic        fetch_done,
  output logic        busy
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  ir_q, ir_d;
  logic         pend_q, pend_d;
  logic [31:0]  pend_pc_q, pend_pc_d;
  logic [31:0]  target;

  pc_next_mux u_pc_next_mux (
    .pc_src_i        (pc_src),
    .pc_i            (pc_q),
    .jidx_i          (ir_q[25:0]),
    .branch_target_i (branch_target),
    .jr_target_i     (jr_target),
    .target_o        (target)
  );

`ifdef FETCH_EXC_VECTOR_EN
  logic [31:0] epc_q, epc_d;
  logic        abort_q, abort_d;
`endif

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    pend_d    = pend_q;
    pend_pc_d = pend_pc_q;
`ifdef FETCH_EXC_VECTOR_EN
    epc_d     = epc_q;
    abort_d   = abort_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (pc_write) pc_d = target;
        if (ir_write) state_d = ST_REQ;
`ifdef FETCH_EXC_VECTOR_EN
        if (exc_req) begin
          epc_d   = pc_q - 32'd4;
          pc_d    = EXC_VECTOR;
          pend_d  = 1'b0;
          state_d = ST_IDLE;
        end
`endif
      end
      ST_REQ: begin
        if (pc_write) begin
          pend_d    = 1'b1;
          pend_pc_d = target;
        end
        state_d = ST_WAIT;
`ifdef FETCH_EXC_VECTOR_EN
        if (exc_req) abort_d = 1'b1;
`endif
      end
      ST_WAIT: begin
        if (pc_write) begin
          pend_d    = 1'b1;
          pend_pc_d = target;
        end
        if (mem_ack) begin
          ir_d    = mem_rdata;
          pc_d    = pc_q + 32'd4;
          state_d = ST_DONE;
        end
`ifdef FETCH_EXC_VECTOR_EN
        if (exc_req) abort_d = 1'b1;
        // An aborted fetch still waits for the bus ack, then discards the word.
        if (mem_ack && (abort_q || exc_req)) begin
          ir_d    = ir_q;
          epc_d   = pc_q - 32'd4;
          pc_d    = EXC_VECTOR;
          pend_d  = 1'b0;
          abort_d = 1'b0;
          state_d = ST_IDLE;
        end
`endif
      end
      ST_DONE: begin
        if (pc_write)    pc_d = target;
        else if (pend_q) pc_d = pend_pc_q;
        pend_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      pc_q      <= RESET_PC;
      ir_q      <= 32'h0;
      pend_q    <= 1'b0;
      pend_pc_q <= 32'h0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      pend_q    <= pend_d;
      pend_pc_q <= pend_pc_d;
    end
  end

`ifdef FETCH_EXC_VECTOR_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      epc_q   <= 32'h0;
      abort_q <= 1'b0;
    end else begin
      epc_q   <= epc_d;
      abort_q <= abort_d;
    end
  end
  assign epc = epc_q;
`else
  // epc is constant zero; the masking just keeps the unused inputs referenced.
  assign epc = EXC_VECTOR & {32{exc_req}} & 32'h0;
`endif

  assign mem_req    = (state_q == ST_REQ) || (state_q == ST_WAIT);
  assign mem_addr   = pc_q;
  assign busy       = (state_q != ST_IDLE);
  assign fetch_done = (state_q == ST_DONE);
  assign pc         = pc_q;

  assign opcode = ir_q[31:26];
  assign rs     = ir_q[25:21];
  assign rt     = ir_q[20:16];
  assign rd     = ir_q[15:11];
  assign imm    = ir_q[15:0];
  assign funct  = ir_q[5:0];

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
// ============================================================================
// tb_instr_fetch_unit : table-driven fetch vectors with a decode scoreboard
// Rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_instr_fetch_unit;
  import instr_fetch_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset, ir_write, pc_write, exc_req, mem_ack;
  logic [1:0]  pc_src;
  logic [31:0] branch_target, jr_target, mem_rdata;
  logic        mem_req, fetch_done, busy;
  logic [31:0] mem_addr, pc, epc;
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm;

  instr_fetch_unit dut (
    .clk(clk), .reset(reset), .ir_write(ir_write), .pc_write(pc_write),
    .pc_src(pc_src), .branch_target(branch_target), .jr_target(jr_target),
    .exc_req(exc_req), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .opcode(opcode), .funct(funct),
    .rs(rs), .rt(rt), .rd(rd), .imm(imm), .pc(pc), .epc(epc),
    .fetch_done(fetch_done), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] imm;
  } dec_t;

  typedef struct {
    logic [31:0] rdata;
    int          delay;
    bit          wr_in_wait;
    dec_t        exp;
  } vec_t;

  dec_t        sb_q[$];
  dec_t        mon_e;
  vec_t        vecs[5];
  int          n_cmp  = 0;
  int          n_err  = 0;
  int          n_done = 0;
  int          n_push = 0;
  logic [31:0] pc_m;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: every fetch_done pops one expected decode.
  always @(negedge clk) begin
    if (fetch_done) begin
      n_done++;
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL sb_unexpected_done: got fetch_done=1 expected no pulse");
      end else begin
        mon_e = sb_q.pop_front();
        chk("sb_opcode", {26'h0, opcode}, {26'h0, mon_e.op});
        chk("sb_funct",  {26'h0, funct},  {26'h0, mon_e.fn});
        chk("sb_rs",     {27'h0, rs},     {27'h0, mon_e.rs});
        chk("sb_rt",     {27'h0, rt},     {27'h0, mon_e.rt});
        chk("sb_rd",     {27'h0, rd},     {27'h0, mon_e.rd});
        chk("sb_imm",    {16'h0, imm},    {16'h0, mon_e.imm});
      end
    end
  end

  task automatic fetch(input logic [31:0] rdata, input int delay, input bit wr_in_wait,
                       input dec_t exp);
    logic [31:0] addr;
    addr = pc_m;
    ir_write = 1'b1;
    sb_q.push_back(exp);
    n_push++;
    @(negedge clk);
    ir_write = 1'b0;
    chk("req_busy", {31'h0, busy}, 32'd1);
    chk("req_mem_req", {31'h0, mem_req}, 32'd1);
    chk("req_addr", mem_addr, addr);
    @(negedge clk);
    for (int k = 0; k < delay; k++) begin
      chk("wait_mem_req", {31'h0, mem_req}, 32'd1);
      chk("wait_addr", mem_addr, addr);
      chk("wait_no_done", {31'h0, fetch_done}, 32'd0);
      ir_write = wr_in_wait;
      @(negedge clk);
    end
    ir_write  = 1'b0;
    mem_ack   = 1'b1;
    mem_rdata = rdata;
    @(negedge clk);
    mem_ack   = 1'b0;
    mem_rdata = 32'h0BAD_F00D;
    chk("done_pulse", {31'h0, fetch_done}, 32'd1);
    chk("done_pc", pc, addr + 32'd4);
    @(negedge clk);
    chk("done_once", {31'h0, fetch_done}, 32'd0);
    chk("idle_busy", {31'h0, busy}, 32'd0);
    pc_m = addr + 32'd4;
  endtask

  task automatic pcw(input logic [1:0] src, input logic [31:0] br, input logic [31:0] jr);
    pc_write = 1'b1;
    pc_src = src;
    branch_target = br;
    jr_target = jr;
    @(negedge clk);
    pc_write = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; ir_write = 1'b0; pc_write = 1'b0; exc_req = 1'b0; mem_ack = 1'b0;
    pc_src = PCSRC_SEQ; branch_target = 32'h0; jr_target = 32'h0; mem_rdata = 32'h0;

    vecs[0] = '{32'h0000_0020, 0, 1'b0, '{6'h00, 6'h20, 5'd0, 5'd0, 5'd0, 16'h0020}};
    vecs[1] = '{32'h8D09_0004, 5, 1'b1, '{6'h23, 6'h04, 5'd8, 5'd9, 5'd0, 16'h0004}};
    vecs[2] = '{32'h0128_5020, 2, 1'b0, '{6'h00, 6'h20, 5'd9, 5'd8, 5'd10, 16'h5020}};
    vecs[3] = '{32'hFFFF_FFFF, 1, 1'b1, '{6'h3F, 6'h3F, 5'd31, 5'd31, 5'd31, 16'hFFFF}};
    vecs[4] = '{32'h0800_0010, 0, 1'b0, '{6'h02, 6'h10, 5'd0, 5'd0, 5'd0, 16'h0010}};

    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("rst_pc", pc, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'd0);
    chk("rst_mem_req", {31'h0, mem_req}, 32'd0);
    chk("rst_fetch_done", {31'h0, fetch_done}, 32'd0);
    chk("rst_epc", epc, 32'h0);
    chk("rst_ir", {opcode, rs, rt, imm}, 32'h0);
    pc_m = 32'h0;

    for (int i = 0; i < 5; i++)
      fetch(vecs[i].rdata, vecs[i].delay, vecs[i].wr_in_wait, vecs[i].exp);
    chk("seq_pc", pc, 32'd20);

    // PC source selection in IDLE with IR = 0x0800_0010
    pcw(PCSRC_BR, 32'h1000_0004, 32'h0);
    chk("pcw_br", pc, 32'h1000_0004);
    pcw(PCSRC_J, 32'h0, 32'h0);
    chk("pcw_j", pc, 32'h1000_0040);
    pcw(PCSRC_SEQ, 32'hDEAD_0000, 32'hDEAD_0000);
    chk("pcw_seq", pc, 32'h1000_0040);
    pcw(PCSRC_JR, 32'h0, 32'h0000_1234);
    chk("pcw_jr", pc, 32'h0000_1234);
    chk("pcw_ir_kept", {26'h0, opcode}, 32'd2);
    pc_m = 32'h0000_1234;

`ifndef FETCH_EXC_VECTOR_EN
    exc_req = 1'b1;
    @(negedge clk);
    exc_req = 1'b0;
    chk("exc_off_pc", pc, 32'h0000_1234);
    chk("exc_off_epc", epc, 32'h0);
`endif

    // Pending pc_write during fetch: the later strobe wins and overrides pc+4
    ir_write = 1'b1;
    sb_q.push_back(vecs[2].exp);
    n_push++;
    @(negedge clk);
    ir_write = 1'b0;
    pc_write = 1'b1; pc_src = PCSRC_JR; jr_target = 32'h200;
    @(negedge clk);
    pc_write = 1'b1; pc_src = PCSRC_BR; branch_target = 32'h100;
    @(negedge clk);
    pc_write = 1'b0;
    chk("pend_addr", mem_addr, 32'h0000_1234);
    chk("pend_pc_held", pc, 32'h0000_1234);
    mem_ack = 1'b1; mem_rdata = 32'h0128_5020;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("pend_done", {31'h0, fetch_done}, 32'd1);
    @(negedge clk);
    chk("pend_pc", pc, 32'h100);
    chk("pend_idle", {31'h0, busy}, 32'd0);

    // PC wrap
    pcw(PCSRC_JR, 32'h0, 32'hFFFF_FFFC);
    pc_m = 32'hFFFF_FFFC;
    fetch(vecs[1].rdata, 1, 1'b0, vecs[1].exp);
    chk("wrap_pc", pc, 32'h0);

    // Reset during WAIT, then a stale ack
    ir_write = 1'b1;
    @(negedge clk);
    ir_write = 1'b0;
    @(negedge clk);
    chk("rw_mem_req_before", {31'h0, mem_req}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rw_mem_req", {31'h0, mem_req}, 32'd0);
    chk("rw_busy", {31'h0, busy}, 32'd0);
    chk("rw_pc", pc, 32'h0);
    mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    repeat (2) @(negedge clk);
    mem_ack = 1'b0;
    chk("stale_busy", {31'h0, busy}, 32'd0);
    chk("stale_ir", {opcode, rs, rt, imm}, 32'h0);
    chk("stale_pc", pc, 32'h0);
    pc_m = 32'h0;

`ifdef FETCH_EXC_VECTOR_EN
    pcw(PCSRC_JR, 32'h0, 32'h4);
    pc_m = 32'h4;
    fetch(vecs[2].rdata, 0, 1'b0, vecs[2].exp);
    exc_req = 1'b1;
    pc_write = 1'b1; pc_src = PCSRC_JR; jr_target = 32'h777;
    @(negedge clk);
    exc_req = 1'b0; pc_write = 1'b0;
    chk("exc_idle_pc", pc, 32'h8000_0180);
    chk("exc_idle_epc", epc, 32'h4);
    pcw(PCSRC_JR, 32'h0, 32'h8);
    ir_write = 1'b1;
    @(negedge clk);
    ir_write = 1'b0;
    @(negedge clk);
    exc_req = 1'b1;
    @(negedge clk);
    exc_req = 1'b0;
    chk("exc_wait_req_held", {31'h0, mem_req}, 32'd1);
    mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("exc_wait_no_done", {31'h0, fetch_done}, 32'd0);
    chk("exc_wait_idle", {31'h0, busy}, 32'd0);
    chk("exc_wait_pc", pc, 32'h8000_0180);
    chk("exc_wait_epc", epc, 32'h4);
    chk("exc_wait_ir", {16'h0, imm}, 32'h5020);
    @(negedge clk);
`endif

    repeat (2) @(negedge clk);
    chk("sb_empty", sb_q.size(), 32'd0);
    chk("done_count", n_done, n_push);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
